// File: rtl/grf_pkg.sv
// Shared definitions for the grf register file: sizes, the zero-register
// constant, the write-trace beat layout and small datapath helpers.
package grf_pkg;

    localparam int NREG = 32;
    localparam int DW   = 32;
    localparam int AW   = 5;

    localparam logic [AW-1:0] REG_ZERO = 5'd0;
    localparam logic [31:0]   CNT_MAX  = 32'hFFFF_FFFF;

    // One retired write as seen on the trace outputs.
    typedef struct packed {
        logic [DW-1:0] pc;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } trace_beat_t;

    // A write only changes architectural state when it targets a real register.
    function automatic logic wr_effective(input logic we, input logic [AW-1:0] a3);
        return we && (a3 != REG_ZERO);
    endfunction

    // Increment that sticks at all-ones instead of wrapping back to zero.
    function automatic logic [31:0] sat_inc(input logic [31:0] cnt);
        logic [31:0] nxt;
        if (cnt == CNT_MAX) begin
            nxt = CNT_MAX;
        end else begin
            nxt = cnt + 32'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/grf_read_port.sv
// One D-stage read port: selects the addressed register, forces index 0 to
// zero, bypasses same-cycle write data and flags reads of unwritten registers.
module grf_read_port
    import grf_pkg::*;
(
    input  logic [AW-1:0]            addr_i,
    input  logic                     use_i,
    input  logic                     we_i,
    input  logic [AW-1:0]            a3_i,
    input  logic [DW-1:0]            wd_i,
    input  logic [NREG-1:0][DW-1:0]  regs_i,
    input  logic [NREG-1:0]          written_i,
    output logic [DW-1:0]            rd_o,
    output logic                     uninit_o
);

    logic w_zero;
    logic w_hit;

    assign w_zero = (addr_i == REG_ZERO);
    // The bypass ignores reset on purpose: reset only blocks the stored update.
    assign w_hit  = we_i && (a3_i == addr_i);

    // Read mux: zero register, then same-cycle write data, then stored value.
    always_comb begin
        rd_o = {DW{1'b0}};
        if (w_zero) begin
            rd_o = {DW{1'b0}};
        end else if (w_hit) begin
            rd_o = wd_i;
        end else begin
            rd_o = regs_i[addr_i];
        end
    end

    // A consumed read is uninitialised unless the register was written
    // earlier or is being written in this very cycle.
    always_comb begin
        uninit_o = 1'b0;
        if (use_i && !w_zero && !written_i[addr_i] && !w_hit) begin
            uninit_o = 1'b1;
        end else begin
            uninit_o = 1'b0;
        end
    end

endmodule

// File: rtl/grf_regfile.sv
// Register file at the end of the write-back path. Holds the architectural
// registers, a written bitmap, a saturating write counter and a one-cycle
// registered write trace; two grf_read_port instances serve the D stage.
module grf_regfile
    import grf_pkg::*;
#(
    // Value the write counter takes on reset; nonzero only for test harnesses
    // that need to reach saturation without billions of writes.
    parameter logic [31:0] P_CNT_RST = 32'h0000_0000
)
(
    input  logic          clk,
    input  logic          reset,
    input  logic          we_i,
    input  logic [AW-1:0] a3_i,
    input  logic [DW-1:0] wd_i,
    input  logic [DW-1:0] pc_w_i,
    input  logic [AW-1:0] a1_i,
    input  logic [AW-1:0] a2_i,
    input  logic          use1_i,
    input  logic          use2_i,
    output logic [DW-1:0] rd1_o,
    output logic [DW-1:0] rd2_o,
    output logic          uninit_rd_o,
    output logic          trace_vld_o,
    output logic [DW-1:0] trace_pc_o,
    output logic [AW-1:0] trace_a_o,
    output logic [DW-1:0] trace_d_o,
    output logic [31:0]   wr_cnt_o
);

    logic [NREG-1:0][DW-1:0] r_regs;
    logic [NREG-1:0]         r_written;
    logic [31:0]             r_wr_cnt;
    logic                    r_trace_vld;
    trace_beat_t             r_trace;

    logic                    w_wr_eff;
    trace_beat_t             w_trace_nxt;
    logic                    w_uninit1;
    logic                    w_uninit2;

    assign w_wr_eff = wr_effective(we_i, a3_i);

    // Register array and written bitmap; index 0 is never stored, and its
    // bitmap bit is set at reset so it never counts as uninitialised.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_regs    <= {(NREG*DW){1'b0}};
            r_written <= {{(NREG-1){1'b0}}, 1'b1};
        end else if (w_wr_eff) begin
            r_regs[a3_i]    <= wd_i;
            r_written[a3_i] <= 1'b1;
        end else begin
            r_regs    <= r_regs;
            r_written <= r_written;
        end
    end

    // Count of effective writes, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_cnt <= P_CNT_RST;
        end else if (w_wr_eff) begin
            r_wr_cnt <= sat_inc(r_wr_cnt);
        end else begin
            r_wr_cnt <= r_wr_cnt;
        end
    end

    // Trace beat for the write being retired; data shows what is really
    // stored, so writes to register 0 report zero.
    always_comb begin
        w_trace_nxt      = '{pc: {DW{1'b0}}, addr: REG_ZERO, data: {DW{1'b0}}};
        w_trace_nxt.pc   = pc_w_i;
        w_trace_nxt.addr = a3_i;
        if (a3_i == REG_ZERO) begin
            w_trace_nxt.data = {DW{1'b0}};
        end else begin
            w_trace_nxt.data = wd_i;
        end
    end

    // Trace valid pulses once per write (including to register 0); fields hold otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_trace_vld <= 1'b0;
            r_trace     <= '{pc: {DW{1'b0}}, addr: REG_ZERO, data: {DW{1'b0}}};
        end else if (we_i) begin
            r_trace_vld <= 1'b1;
            r_trace     <= w_trace_nxt;
        end else begin
            r_trace_vld <= 1'b0;
            r_trace     <= r_trace;
        end
    end

    grf_read_port u_rp1 (
        .addr_i    (a1_i),
        .use_i     (use1_i),
        .we_i      (we_i),
        .a3_i      (a3_i),
        .wd_i      (wd_i),
        .regs_i    (r_regs),
        .written_i (r_written),
        .rd_o      (rd1_o),
        .uninit_o  (w_uninit1)
    );

    grf_read_port u_rp2 (
        .addr_i    (a2_i),
        .use_i     (use2_i),
        .we_i      (we_i),
        .a3_i      (a3_i),
        .wd_i      (wd_i),
        .regs_i    (r_regs),
        .written_i (r_written),
        .rd_o      (rd2_o),
        .uninit_o  (w_uninit2)
    );

    assign uninit_rd_o = w_uninit1 | w_uninit2;
    assign trace_vld_o = r_trace_vld;
    assign trace_pc_o  = r_trace.pc;
    assign trace_a_o   = r_trace.addr;
    assign trace_d_o   = r_trace.data;
    assign wr_cnt_o    = r_wr_cnt;

endmodule

// File: tb/tb_grf_regfile.sv
// Directed scoreboard bench for grf_regfile. A driver applies one input
// vector per cycle and queues the hand-computed outputs for that cycle; a
// monitor pops and compares them mid-cycle. A second instance starts its
// counter near all-ones to exercise saturation.
module tb_grf_regfile;

    logic        clk = 1'b0;
    logic        reset;
    logic        we;
    logic [4:0]  a3, a1, a2;
    logic [31:0] wd, pc;
    logic        use1, use2;

    logic [31:0] rd1, rd2, tpc, td, cnt;
    logic        unin, tv;
    logic [4:0]  ta;

    logic [31:0] s_rd1, s_rd2, s_tpc, s_td, s_cnt;
    logic        s_unin, s_tv;
    logic [4:0]  s_ta;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic        unin;
        logic        tv;
        logic [4:0]  ta;
        logic [31:0] tpc;
        logic [31:0] td;
        logic [31:0] cnt;
        logic [31:0] scnt;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;

    grf_regfile dut (
        .clk(clk), .reset(reset), .we_i(we), .a3_i(a3), .wd_i(wd), .pc_w_i(pc),
        .a1_i(a1), .a2_i(a2), .use1_i(use1), .use2_i(use2),
        .rd1_o(rd1), .rd2_o(rd2), .uninit_rd_o(unin), .trace_vld_o(tv),
        .trace_pc_o(tpc), .trace_a_o(ta), .trace_d_o(td), .wr_cnt_o(cnt)
    );

    grf_regfile #(.P_CNT_RST(32'hFFFF_FFFE)) dut_sat (
        .clk(clk), .reset(reset), .we_i(we), .a3_i(a3), .wd_i(wd), .pc_w_i(pc),
        .a1_i(a1), .a2_i(a2), .use1_i(use1), .use2_i(use2),
        .rd1_o(s_rd1), .rd2_o(s_rd2), .uninit_rd_o(s_unin), .trace_vld_o(s_tv),
        .trace_pc_o(s_tpc), .trace_a_o(s_ta), .trace_d_o(s_td), .wr_cnt_o(s_cnt)
    );

    task automatic chk(input string name, input int step, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %h expected %h", name, step, act, exp);
        end
    endtask

    task automatic drv(input logic rst_v, input logic we_v, input logic [4:0] a3_v,
                       input logic [31:0] wd_v, input logic [31:0] pc_v,
                       input logic [4:0] a1_v, input logic [4:0] a2_v,
                       input logic u1_v, input logic u2_v);
        reset = rst_v; we = we_v; a3 = a3_v; wd = wd_v; pc = pc_v;
        a1 = a1_v; a2 = a2_v; use1 = u1_v; use2 = u2_v;
    endtask

    task automatic push(input logic [31:0] e_rd1, input logic [31:0] e_rd2, input logic e_unin,
                        input logic e_tv, input logic [4:0] e_ta, input logic [31:0] e_tpc,
                        input logic [31:0] e_td, input logic [31:0] e_cnt, input logic [31:0] e_scnt);
        exp_t e;
        e.rd1 = e_rd1; e.rd2 = e_rd2; e.unin = e_unin; e.tv = e_tv; e.ta = e_ta;
        e.tpc = e_tpc; e.td = e_td; e.cnt = e_cnt; e.scnt = e_scnt;
        q.push_back(e);
    endtask

    // Monitor: compare the oldest queued expectation against the DUT mid-cycle.
    int step_no = 0;
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("rd1",       step_no, rd1,            e.rd1);
            chk("rd2",       step_no, rd2,            e.rd2);
            chk("uninit",    step_no, {31'd0, unin},  {31'd0, e.unin});
            chk("trace_vld", step_no, {31'd0, tv},    {31'd0, e.tv});
            chk("trace_a",   step_no, {27'd0, ta},    {27'd0, e.ta});
            chk("trace_pc",  step_no, tpc,            e.tpc);
            chk("trace_d",   step_no, td,             e.td);
            chk("wr_cnt",    step_no, cnt,            e.cnt);
            chk("sat_cnt",   step_no, s_cnt,          e.scnt);
            step_no++;
        end
    end

    initial begin
        drv(1'b1, 1'b0, 5'd0, 32'd0, 32'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        //   rst   we    a3     wd             pc             a1     a2     u1    u2
        // 0: reset state
        drv(1'b0, 1'b0, 5'd0,  32'd0,         32'd0,         5'd5,  5'd31, 1'b0, 1'b0);
        push(32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFE);
        // 1: write r8, same-cycle bypass on port 1, used read not flagged
        @(posedge clk); #1;
        drv(1'b0, 1'b1, 5'd8,  32'hDEAD_BEEF, 32'h0000_3000, 5'd8,  5'd5,  1'b1, 1'b0);
        push(32'hDEAD_BEEF, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFE);
        // 2: stored value on both ports, first trace beat, counters advance
        @(posedge clk); #1;
        drv(1'b0, 1'b0, 5'd0,  32'd0,         32'd0,         5'd8,  5'd8,  1'b1, 1'b1);
        push(32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1'b1, 5'd8, 32'h0000_3000, 32'hDEAD_BEEF, 32'd1, 32'hFFFF_FFFF);
        // 3: write to r0, reading r0 gives 0, trace fields hold
        @(posedge clk); #1;
        drv(1'b0, 1'b1, 5'd0,  32'h0000_1234, 32'h0000_3004, 5'd0,  5'd8,  1'b0, 1'b0);
        push(32'd0, 32'hDEAD_BEEF, 1'b0, 1'b0, 5'd8, 32'h0000_3000, 32'hDEAD_BEEF, 32'd1, 32'hFFFF_FFFF);
        // 4: r0 write traced with data 0, count unchanged; dual bypass of r8
        @(posedge clk); #1;
        drv(1'b0, 1'b1, 5'd8,  32'h55AA_55AA, 32'h0000_3008, 5'd8,  5'd8,  1'b0, 1'b0);
        push(32'h55AA_55AA, 32'h55AA_55AA, 1'b0, 1'b1, 5'd0, 32'h0000_3004, 32'd0, 32'd1, 32'hFFFF_FFFF);
        // 5: back-to-back write, saturated counter stays at all-ones
        @(posedge clk); #1;
        drv(1'b0, 1'b1, 5'd31, 32'h0F0F_0F0F, 32'h0000_300C, 5'd8,  5'd31, 1'b1, 1'b1);
        push(32'h55AA_55AA, 32'h0F0F_0F0F, 1'b0, 1'b1, 5'd8, 32'h0000_3008, 32'h55AA_55AA, 32'd2, 32'hFFFF_FFFF);
        // 6: top register readback
        @(posedge clk); #1;
        drv(1'b0, 1'b0, 5'd0,  32'd0,         32'd0,         5'd31, 5'd0,  1'b1, 1'b0);
        push(32'h0F0F_0F0F, 32'd0, 1'b0, 1'b1, 5'd31, 32'h0000_300C, 32'h0F0F_0F0F, 32'd3, 32'hFFFF_FFFF);
        // 7: write r4 during reset; bypass still visible this cycle
        @(posedge clk); #1;
        drv(1'b1, 1'b1, 5'd4,  32'hCAFE_F00D, 32'h0000_3010, 5'd4,  5'd31, 1'b0, 1'b0);
        push(32'hCAFE_F00D, 32'h0F0F_0F0F, 1'b0, 1'b0, 5'd31, 32'h0000_300C, 32'h0F0F_0F0F, 32'd3, 32'hFFFF_FFFF);
        // 8: reset won: r4 still 0 and uninitialised, everything cleared
        @(posedge clk); #1;
        drv(1'b0, 1'b0, 5'd0,  32'd0,         32'd0,         5'd4,  5'd31, 1'b1, 1'b0);
        push(32'd0, 32'd0, 1'b1, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFE);
        // 9: used read of never-written r9
        @(posedge clk); #1;
        drv(1'b0, 1'b0, 5'd0,  32'd0,         32'd0,         5'd9,  5'd0,  1'b1, 1'b0);
        push(32'd0, 32'd0, 1'b1, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFE);
        // 10: same read while r9 is being written: bypass clears the flag
        @(posedge clk); #1;
        drv(1'b0, 1'b1, 5'd9,  32'h0000_0009, 32'h0000_3014, 5'd9,  5'd0,  1'b1, 1'b0);
        push(32'h0000_0009, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFE);
        // 11: unused port on unwritten r10 not flagged; r9 now written
        @(posedge clk); #1;
        drv(1'b0, 1'b0, 5'd0,  32'd0,         32'd0,         5'd10, 5'd9,  1'b0, 1'b1);
        push(32'd0, 32'h0000_0009, 1'b0, 1'b1, 5'd9, 32'h0000_3014, 32'h0000_0009, 32'd1, 32'hFFFF_FFFF);
        // 12: port 2 alone raises the flag
        @(posedge clk); #1;
        drv(1'b0, 1'b0, 5'd0,  32'd0,         32'd0,         5'd11, 5'd12, 1'b0, 1'b1);
        push(32'd0, 32'd0, 1'b1, 1'b0, 5'd9, 32'h0000_3014, 32'h0000_0009, 32'd1, 32'hFFFF_FFFF);

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 10; i++) begin
            if (q.size() > 0) begin
                @(posedge clk);
            end
        end
        n_chk++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
